// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, waits on data memory,
// traps or skips illegal encodings and counts retired instructions.
module mc_ctrl #(
  parameter int       MEM_LAT      = 0,
  parameter bit       ILLEGAL_TRAP = 1'b1,
  parameter int       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       dm_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_SLL, C_JR, C_ORI, C_LUI, C_LW,
    C_LB, C_LH, C_SW, C_SB, C_SH, C_BEQ, C_BNE, C_JAL
  } class_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     cur_state, nxt_state;
  class_t     cls, dec_cls;
  logic [3:0] wait_cnt;
  logic       is_load, is_store, is_rtype;

  always_comb begin
    dec_cls = C_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: dec_cls = C_ADD;
          6'b100010: dec_cls = C_SUB;
          6'b000000: dec_cls = C_SLL;
          6'b001000: dec_cls = C_JR;
          default:   dec_cls = C_ILL;
        endcase
      end
      6'b001101: dec_cls = C_ORI;
      6'b001111: dec_cls = C_LUI;
      6'b100011: dec_cls = C_LW;
      6'b100000: dec_cls = C_LB;
      6'b100001: dec_cls = C_LH;
      6'b101011: dec_cls = C_SW;
      6'b101000: dec_cls = C_SB;
      6'b101001: dec_cls = C_SH;
      6'b000100: dec_cls = C_BEQ;
      6'b000101: dec_cls = C_BNE;
      6'b000011: dec_cls = C_JAL;
      default:   dec_cls = C_ILL;
    endcase
  end

  assign is_load  = (cls == C_LW) || (cls == C_LB) || (cls == C_LH);
  assign is_store = (cls == C_SW) || (cls == C_SB) || (cls == C_SH);
  assign is_rtype = (cls == C_ADD) || (cls == C_SUB) || (cls == C_SLL);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // The wait counter is reloaded every EXEC cycle so it always holds MEM_LAT on MEM entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cls         <= C_ILL;
      wait_cnt    <= 4'd0;
      instr_count <= '0;
    end else begin
      if (cur_state == S_DECODE) cls <= dec_cls;
      if (cur_state == S_EXEC) wait_cnt <= LAT;
      else if (cur_state == S_MEM && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (dec_cls != C_ILL) nxt_state = S_EXEC;
        else if (ILLEGAL_TRAP) nxt_state = S_HALT;
        else nxt_state = S_FETCH;
      end
      S_EXEC: begin
        if (is_rtype || cls == C_ORI || cls == C_LUI) nxt_state = S_WB;
        else if (is_load || is_store) nxt_state = S_MEM;
        else nxt_state = S_FETCH;
      end
      S_MEM: begin
        if (wait_cnt == 4'd0) nxt_state = is_load ? S_WB : S_FETCH;
      end
      S_WB:     nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    ext_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    dm_op      = 3'b000;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (dec_cls == C_ILL && !ILLEGAL_TRAP) instr_done = 1'b1;
      end
      S_EXEC: begin
        case (cls)
          C_ADD: alu_op = 4'b0010;
          C_SUB: alu_op = 4'b0011;
          C_SLL: alu_op = 4'b0100;
          C_ORI: begin
            alu_op  = 4'b0001;
            alu_src = 1'b1;
          end
          C_LUI: begin
            alu_op  = 4'b0001;
            alu_src = 1'b1;
            ext_op  = 2'b10;
          end
          C_LW, C_LB, C_LH, C_SW, C_SB, C_SH: begin
            alu_op  = 4'b0010;
            alu_src = 1'b1;
            ext_op  = 2'b01;
          end
          C_BEQ, C_BNE: begin
            alu_op     = 4'b0011;
            ext_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = (cls == C_BEQ) ? zero : !zero;
            instr_done = 1'b1;
          end
          C_JR: begin
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            instr_done = 1'b1;
          end
          C_JAL: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        case (cls)
          C_LB:    dm_op = 3'b001;
          C_LH:    dm_op = 3'b010;
          C_SB:    dm_op = 3'b011;
          C_SH:    dm_op = 3'b100;
          default: dm_op = 3'b000;
        endcase
        mem_read   = is_load;
        mem_write  = is_store && (wait_cnt == LAT);
        instr_done = is_store && (wait_cnt == 4'd0);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        mem_to_reg = is_load ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset suppresses every side effect so an abandoned instruction writes nothing.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

  assign state = cur_state;

endmodule
